// File: rtl/instruction_queue_pkg.sv
// Shared types for the instruction queue: instruction-type codes and the
// packed entry layout held in queue storage.
package instruction_queue_pkg;

  localparam int QUEUE_ADDR_W = 18;

  localparam logic [1:0] INSTR_TYPE_RAM        = 2'd0;
  localparam logic [1:0] INSTR_TYPE_LOAD_STORE = 2'd1;
  localparam logic [1:0] INSTR_TYPE_ARITHMETIC = 2'd2;
  localparam logic [1:0] INSTR_TYPE_LOOP       = 2'd3;

  typedef struct packed {
    logic [1:0]              instr_type;
    logic [15:0]             instr;
    logic [QUEUE_ADDR_W-1:0] cache_addr;
    logic [QUEUE_ADDR_W-1:0] main_mem_addr;
    logic [QUEUE_ADDR_W-1:0] d_cache_addr;
    logic [QUEUE_ADDR_W-1:0] d_main_mem_addr;
  } queue_entry_t;

  // LOOP entries have no execution consumer, so they are never queued.
  function automatic logic is_queueable_type(input logic [1:0] instr_type);
    return instr_type != INSTR_TYPE_LOOP;
  endfunction

endpackage

// File: rtl/instruction_queue_storage.sv
// Entry storage for the instruction queue: one synchronous write port and
// one asynchronous read port; contents are intentionally not reset.
module instruction_queue_storage
  import instruction_queue_pkg::*;
#(
  parameter int LOG_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [LOG_DEPTH-1:0] waddr,
  input  queue_entry_t         wdata,
  input  logic [LOG_DEPTH-1:0] raddr,
  output queue_entry_t         rdata
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  queue_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_queue.sv
// In-order instruction FIFO between control_unit and the RAM, load/store and
// arithmetic units; the head entry is offered to exactly one unit by type.
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int LOG_DEPTH = 3,
  parameter int ADDR_W    = QUEUE_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 queue_we,
  input  logic [1:0]           queue_instr_type,
  input  logic [15:0]          queue_instr,
  input  logic [ADDR_W-1:0]    cache_addr,
  input  logic [ADDR_W-1:0]    main_mem_addr,
  input  logic [ADDR_W-1:0]    d_cache_addr,
  input  logic [ADDR_W-1:0]    d_main_mem_addr,
  output logic                 full,
  output logic                 empty,
  output logic [LOG_DEPTH:0]   count,
  output logic                 overflow,
  output logic [15:0]          head_instr,
  output logic [ADDR_W-1:0]    head_cache_addr,
  output logic [ADDR_W-1:0]    head_main_mem_addr,
  output logic [ADDR_W-1:0]    head_d_cache_addr,
  output logic [ADDR_W-1:0]    head_d_main_mem_addr,
  output logic                 ram_valid,
  input  logic                 ram_ready,
  output logic                 ls_valid,
  input  logic                 ls_ready,
  output logic                 arith_valid,
  input  logic                 arith_ready
);

  localparam int               DEPTH      = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] FULL_COUNT = (LOG_DEPTH + 1)'(DEPTH);

  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;
  queue_entry_t         wr_entry;
  queue_entry_t         head;
  logic                 push;
  logic                 pop;
  logic                 drop;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // full comes from the registered count, so a same-cycle pop never frees a slot for a write
  assign push = queue_we && !full && is_queueable_type(queue_instr_type);
  assign drop = queue_we && (full || !is_queueable_type(queue_instr_type));
  assign pop  = (ram_valid && ram_ready) || (ls_valid && ls_ready) ||
                (arith_valid && arith_ready);

  always_comb begin
    wr_entry                 = '0;
    wr_entry.instr_type      = queue_instr_type;
    wr_entry.instr           = queue_instr;
    wr_entry.cache_addr      = cache_addr;
    wr_entry.main_mem_addr   = main_mem_addr;
    wr_entry.d_cache_addr    = d_cache_addr;
    wr_entry.d_main_mem_addr = d_main_mem_addr;
  end

  instruction_queue_storage #(
    .LOG_DEPTH (LOG_DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + LOG_DEPTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + LOG_DEPTH'(1);
      end
      if (push && !pop) begin
        count <= count + (LOG_DEPTH + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (LOG_DEPTH + 1)'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    ram_valid   = 1'b0;
    ls_valid    = 1'b0;
    arith_valid = 1'b0;
    if (!empty) begin
      case (head.instr_type)
        INSTR_TYPE_RAM:        ram_valid   = 1'b1;
        INSTR_TYPE_LOAD_STORE: ls_valid    = 1'b1;
        INSTR_TYPE_ARITHMETIC: arith_valid = 1'b1;
        default: ;
      endcase
    end
  end

  // Stale storage is hidden while empty so the head reads as zero after reset
  assign head_instr           = empty ? '0 : head.instr;
  assign head_cache_addr      = empty ? '0 : head.cache_addr;
  assign head_main_mem_addr   = empty ? '0 : head.main_mem_addr;
  assign head_d_cache_addr    = empty ? '0 : head.d_cache_addr;
  assign head_d_main_mem_addr = empty ? '0 : head.d_main_mem_addr;

endmodule

// File: tb/tb_instruction_queue.sv
// Directed self-checking bench for instruction_queue at LOG_DEPTH=2.
module tb_instruction_queue;
  import instruction_queue_pkg::*;

  localparam int LOG_DEPTH = 2;
  localparam int ADDR_W    = QUEUE_ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              queue_we;
  logic [1:0]        queue_instr_type;
  logic [15:0]       queue_instr;
  logic [ADDR_W-1:0] cache_addr, main_mem_addr, d_cache_addr, d_main_mem_addr;
  logic              full, empty, overflow;
  logic [LOG_DEPTH:0] count;
  logic [15:0]       head_instr;
  logic [ADDR_W-1:0] head_cache_addr, head_main_mem_addr;
  logic [ADDR_W-1:0] head_d_cache_addr, head_d_main_mem_addr;
  logic              ram_valid, ram_ready, ls_valid, ls_ready, arith_valid, arith_ready;

  int checks   = 0;
  int failures = 0;

  instruction_queue #(
    .LOG_DEPTH (LOG_DEPTH),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .queue_we             (queue_we),
    .queue_instr_type     (queue_instr_type),
    .queue_instr          (queue_instr),
    .cache_addr           (cache_addr),
    .main_mem_addr        (main_mem_addr),
    .d_cache_addr         (d_cache_addr),
    .d_main_mem_addr      (d_main_mem_addr),
    .full                 (full),
    .empty                (empty),
    .count                (count),
    .overflow             (overflow),
    .head_instr           (head_instr),
    .head_cache_addr      (head_cache_addr),
    .head_main_mem_addr   (head_main_mem_addr),
    .head_d_cache_addr    (head_d_cache_addr),
    .head_d_main_mem_addr (head_d_main_mem_addr),
    .ram_valid            (ram_valid),
    .ram_ready            (ram_ready),
    .ls_valid             (ls_valid),
    .ls_ready             (ls_ready),
    .arith_valid          (arith_valid),
    .arith_ready          (arith_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] itype,
                               input logic [15:0] instr, input logic [ADDR_W-1:0] ca,
                               input logic [ADDR_W-1:0] mma);
    queue_we         = we;
    queue_instr_type = itype;
    queue_instr      = instr;
    cache_addr       = ca;
    main_mem_addr    = mma;
    d_cache_addr     = ca + 18'd2;
    d_main_mem_addr  = mma + 18'd7;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_order [12];

  initial begin
    reset       = 1'b0;
    ram_ready   = 1'b0;
    ls_ready    = 1'b0;
    arith_ready = 1'b0;
    applyStimulus(1'b0, INSTR_TYPE_RAM, 16'h0, '0, '0);
    tick();
    tick();
    checkOutput("reset_empty", 32'(empty), 32'd1);
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_full", 32'(full), 32'd0);
    checkOutput("reset_valids", {29'd0, ram_valid, ls_valid, arith_valid}, 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;
    tick();
    checkOutput("idle_empty", 32'(empty), 32'd1);

    // Single RAM entry, no same-cycle bypass
    applyStimulus(1'b1, INSTR_TYPE_RAM, 16'h0001, 18'd3, 18'd0);
    #1;
    checkOutput("no_bypass_ram_valid", 32'(ram_valid), 32'd0);
    tick();
    applyStimulus(1'b0, INSTR_TYPE_RAM, 16'h0, '0, '0);
    #1;
    checkOutput("one_ram_valid", 32'(ram_valid), 32'd1);
    checkOutput("one_head_cache", 32'(head_cache_addr), 32'd3);
    checkOutput("one_head_mm", 32'(head_main_mem_addr), 32'd0);
    checkOutput("one_head_dcache", 32'(head_d_cache_addr), 32'd5);
    checkOutput("one_head_dmm", 32'(head_d_main_mem_addr), 32'd7);
    checkOutput("one_count", 32'(count), 32'd1);
    ram_ready = 1'b1;
    tick();
    ram_ready = 1'b0;
    #1;
    checkOutput("one_pop_count", 32'(count), 32'd0);
    checkOutput("one_pop_ram_valid", 32'(ram_valid), 32'd0);

    // RAM head blocks younger LS/ARITH entries even though their units are ready
    ls_ready    = 1'b1;
    arith_ready = 1'b1;
    applyStimulus(1'b1, INSTR_TYPE_RAM, 16'h0010, 18'd16, 18'd1);
    tick();
    applyStimulus(1'b1, INSTR_TYPE_LOAD_STORE, 16'h0011, 18'd17, 18'd2);
    tick();
    applyStimulus(1'b1, INSTR_TYPE_ARITHMETIC, 16'h0012, 18'd18, 18'd3);
    tick();
    applyStimulus(1'b0, INSTR_TYPE_RAM, 16'h0, '0, '0);
    tick();
    checkOutput("block_count", 32'(count), 32'd3);
    checkOutput("block_ls_valid", 32'(ls_valid), 32'd0);
    checkOutput("block_arith_valid", 32'(arith_valid), 32'd0);
    checkOutput("block_ram_valid", 32'(ram_valid), 32'd1);
    ram_ready = 1'b1;
    tick();
    checkOutput("drain1_count", 32'(count), 32'd2);
    checkOutput("drain1_head", 32'(head_instr), 32'h0011);
    checkOutput("drain1_ls_valid", 32'(ls_valid), 32'd1);
    tick();
    checkOutput("drain2_count", 32'(count), 32'd1);
    checkOutput("drain2_head", 32'(head_instr), 32'h0012);
    checkOutput("drain2_arith_valid", 32'(arith_valid), 32'd1);
    tick();
    checkOutput("drain3_count", 32'(count), 32'd0);
    ram_ready   = 1'b0;
    ls_ready    = 1'b0;
    arith_ready = 1'b0;

    // Fill, then a write while full is dropped even though the head pops
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, INSTR_TYPE_RAM, 16'h0020 + 16'(i), 18'(i), 18'(i));
      tick();
    end
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_count", 32'(count), 32'd4);
    checkOutput("fill_overflow_before", 32'(overflow), 32'd0);
    applyStimulus(1'b1, INSTR_TYPE_RAM, 16'h0024, '0, '0);
    ram_ready = 1'b1;
    tick();
    applyStimulus(1'b0, INSTR_TYPE_RAM, 16'h0, '0, '0);
    ram_ready = 1'b0;
    #1;
    checkOutput("full_drop_count", 32'(count), 32'd3);
    checkOutput("full_drop_overflow", 32'(overflow), 32'd1);
    checkOutput("full_drop_head", 32'(head_instr), 32'h0021);
    checkOutput("full_drop_full", 32'(full), 32'd0);
    ram_ready = 1'b1;
    tick();
    ram_ready = 1'b0;
    checkOutput("pre_stream_count", 32'(count), 32'd2);

    // Streaming push+pop at count=2 across pointer wrap
    exp_order[0] = 16'h0022;
    exp_order[1] = 16'h0023;
    for (int i = 0; i < 10; i++) begin
      exp_order[i + 2] = 16'h0030 + 16'(i);
    end
    ram_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, INSTR_TYPE_RAM, 16'h0030 + 16'(i), 18'(i), 18'(i));
      #1;
      checkOutput($sformatf("stream_head_%0d", i), 32'(head_instr), 32'(exp_order[i]));
      tick();
      checkOutput($sformatf("stream_count_%0d", i), 32'(count), 32'd2);
    end
    applyStimulus(1'b0, INSTR_TYPE_RAM, 16'h0, '0, '0);
    ram_ready = 1'b0;
    #1;
    checkOutput("stream_final_head", 32'(head_instr), 32'(exp_order[10]));

    // Asynchronous reset mid-operation with count=3
    applyStimulus(1'b1, INSTR_TYPE_LOAD_STORE, 16'h0040, '0, '0);
    tick();
    applyStimulus(1'b0, INSTR_TYPE_RAM, 16'h0, '0, '0);
    checkOutput("pre_reset_count", 32'(count), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_count", 32'(count), 32'd0);
    checkOutput("async_reset_empty", 32'(empty), 32'd1);
    checkOutput("async_reset_valids", {29'd0, ram_valid, ls_valid, arith_valid}, 32'd0);
    checkOutput("async_reset_overflow", 32'(overflow), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // LOOP type is never queued and flags overflow
    applyStimulus(1'b1, INSTR_TYPE_LOOP, 16'h0050, '0, '0);
    tick();
    applyStimulus(1'b0, INSTR_TYPE_RAM, 16'h0, '0, '0);
    #1;
    checkOutput("loop_count", 32'(count), 32'd0);
    checkOutput("loop_empty", 32'(empty), 32'd1);
    checkOutput("loop_overflow", 32'(overflow), 32'd1);
    tick();
    checkOutput("loop_overflow_sticky", 32'(overflow), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
